// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Read addresses travel as a packed bus; rfUnpackAddr pulls out one port's field.
package rf_pkg;

    localparam int unsigned RF_DATA_W       = 32;
    localparam int unsigned RF_ADDR_W       = 5;
    localparam int unsigned RF_NUM_READ     = 2;

    // Upper bounds for the address bus handed to rfUnpackAddr.
    localparam int unsigned RF_MAX_ADDR_W   = 8;
    localparam int unsigned RF_MAX_NUM_READ = 4;
    localparam int unsigned RF_ADDR_BUS_W   = RF_MAX_ADDR_W * RF_MAX_NUM_READ;

    typedef logic [RF_ADDR_BUS_W-1:0] rfAddrBus_t;
    typedef logic [RF_MAX_ADDR_W-1:0] rfAddr_t;

    // Returns port 'port' of a zero-extended packed address bus.
    // Bits above addrW must be masked or sliced off by the caller.
    function automatic rfAddr_t rfUnpackAddr(
        input rfAddrBus_t  addrBus,
        input int unsigned port,
        input int unsigned addrW
    );
        rfAddrBus_t shifted;
        shifted = addrBus >> (port * addrW);
        return shifted[RF_MAX_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reserve sets a bit, writeback clears it, and a
// registered population count follows the bits exactly.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_READ = RF_NUM_READ,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       setValid,
    input  logic [ADDR_W-1:0]          setAddr,
    input  logic                       clrValid,
    input  logic [ADDR_W-1:0]          clrAddr,
    input  logic [NUM_READ*ADDR_W-1:0] readAddr,
    output logic [NUM_READ-1:0]        readBusy,
    output logic [ADDR_W:0]            busyCount
);

    localparam int unsigned     DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busyNext_s;
    logic [ADDR_W:0]  busyCount_r;
    logic [ADDR_W:0]  countNext_s;
    logic             setEff_s;
    logic             clrEff_s;
    logic             incr_s;
    logic             decr_s;

    assign setEff_s = setValid && !(ZERO_REG && (setAddr == '0));
    assign clrEff_s = clrValid && !(ZERO_REG && (clrAddr == '0));

    // Next busy vector: clear first, then set, so a same-cycle reserve wins.
    always_comb begin
        busyNext_s = busy_r;
        incr_s     = 1'b0;
        decr_s     = 1'b0;
        if (clrEff_s) begin
            busyNext_s[clrAddr] = 1'b0;
            decr_s = busy_r[clrAddr] && !(setEff_s && (setAddr == clrAddr));
        end else begin
            decr_s = 1'b0;
        end
        if (setEff_s) begin
            busyNext_s[setAddr] = 1'b1;
            incr_s = !busy_r[setAddr];
        end else begin
            incr_s = 1'b0;
        end
    end

    // Count follows the set/clear deltas; a set on one register and a clear on another cancel.
    always_comb begin
        countNext_s = busyCount_r;
        if (incr_s && !decr_s) begin
            countNext_s = busyCount_r + CNT_ONE;
        end else if (decr_s && !incr_s) begin
            countNext_s = busyCount_r - CNT_ONE;
        end else begin
            countNext_s = busyCount_r;
        end
    end

    // Busy bits and count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= '0;
            busyCount_r <= '0;
        end else begin
            busy_r      <= busyNext_s;
            busyCount_r <= countNext_s;
        end
    end

    // Raw busy lookup per read port; zero-register and bypass overrides live in the top.
    always_comb begin
        readBusy = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            readBusy[i] = busy_r[readAddr[i*ADDR_W +: ADDR_W]];
        end
    end

    assign busyCount = busyCount_r;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised register file with NUM_READ combinational read ports,
// optional write-through bypass, optional hardwired r0, and a busy scoreboard.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_READ = RF_NUM_READ,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [NUM_READ*ADDR_W-1:0] readReg,
    output logic [NUM_READ*DATA_W-1:0] readData,
    output logic [NUM_READ-1:0]        readBusy,
    input  logic                       rsvValid,
    input  logic [ADDR_W-1:0]          rsvReg,
    output logic [ADDR_W:0]            busyCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                writeEff_s;
    logic [NUM_READ-1:0] sbBusy_s;
    rfAddrBus_t          readRegWide_s;

    assign writeEff_s = regWrite && !(ZERO_REG && (writeReg == '0));

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .setValid  (rsvValid),
        .setAddr   (rsvReg),
        .clrValid  (regWrite),
        .clrAddr   (writeReg),
        .readAddr  (readReg),
        .readBusy  (sbBusy_s),
        .busyCount (busyCount)
    );

    // Data array; reset clears every word so stale values never reappear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < DEPTH; w++) begin
                mem_r[w] <= '0;
            end
        end else if (writeEff_s) begin
            mem_r[writeReg] <= writeData;
        end else begin
            mem_r[writeReg] <= mem_r[writeReg];
        end
    end

    // Read muxing: hardwired zero, then same-cycle write forwarding, then stored state.
    always_comb begin
        logic [ADDR_W-1:0] portAddr;
        rfAddr_t           unpacked;
        portAddr      = '0;
        unpacked      = '0;
        readRegWide_s = '0;
        readRegWide_s[NUM_READ*ADDR_W-1:0] = readReg;
        readData      = '0;
        readBusy      = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            unpacked = rfUnpackAddr(readRegWide_s, i, ADDR_W);
            portAddr = unpacked[ADDR_W-1:0];
            if (ZERO_REG && (portAddr == '0)) begin
                readData[i*DATA_W +: DATA_W] = '0;
                readBusy[i]                  = 1'b0;
            end else if (BYPASS && regWrite && (writeReg == portAddr)) begin
                readData[i*DATA_W +: DATA_W] = writeData;
                readBusy[i]                  = 1'b0;
            end else begin
                readData[i*DATA_W +: DATA_W] = mem_r[portAddr];
                readBusy[i]                  = sbBusy_s[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: a bypass and a non-bypass instance share stimulus; a
// behavioural model feeds an expectation queue that is popped at each sample.
module tb_register_file_mp;
    import rf_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CW    = AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            regWrite;
    logic [AW-1:0]   writeReg;
    logic [DW-1:0]   writeData;
    logic [NR*AW-1:0] readReg;
    logic            rsvValid;
    logic [AW-1:0]   rsvReg;
    logic [NR*DW-1:0] readData, readDataNb;
    logic [NR-1:0]   readBusy, readBusyNb;
    logic [AW:0]     busyCount, busyCountNb;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mMem  [DEPTH];
    logic          mBusy [DEPTH];

    typedef struct {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    busy;
        logic [NR*DW-1:0] dataNb;
        logic [NR-1:0]    busyNb;
        logic [AW:0]      cnt;
    } exp_t;
    exp_t expQ[$];

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .readReg(readReg), .readData(readData), .readBusy(readBusy),
        .rsvValid(rsvValid), .rsvReg(rsvReg), .busyCount(busyCount)
    );

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dutNb (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .readReg(readReg), .readData(readDataNb), .readBusy(readBusyNb),
        .rsvValid(rsvValid), .rsvReg(rsvReg), .busyCount(busyCountNb)
    );

    function automatic logic [AW:0] mCount();
        int n = 0;
        for (int r = 0; r < DEPTH; r++) n += int'(mBusy[r]);
        return CW'(n);
    endfunction

    task automatic expectPort(input logic [AW-1:0] a, input logic byp,
                              output logic [DW-1:0] d, output logic b);
        if (a == '0) begin
            d = '0; b = 1'b0;
        end else if (byp && regWrite && writeReg == a) begin
            d = writeData; b = 1'b0;
        end else begin
            d = mMem[a]; b = mBusy[a];
        end
    endtask

    task automatic modelEdge();
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mMem[r] = '0; mBusy[r] = 1'b0;
            end
        end else begin
            if (regWrite && writeReg != '0) begin
                mMem[writeReg] = writeData; mBusy[writeReg] = 1'b0;
            end
            if (rsvValid && rsvReg != '0) mBusy[rsvReg] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] rr, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst = r; regWrite = w; writeReg = wr; writeData = wd;
        rsvValid = rv; rsvReg = rr; readReg = {a1, a0};
    endtask

    // Push model expectation for the present inputs, let logic settle, then pop and compare.
    task automatic score(input string name);
        exp_t e, chk;
        logic [DW-1:0] d;
        logic b;
        e.cnt = mCount();
        for (int i = 0; i < NR; i++) begin
            expectPort(readReg[i*AW +: AW], 1'b1, d, b);
            e.data[i*DW +: DW] = d; e.busy[i] = b;
            expectPort(readReg[i*AW +: AW], 1'b0, d, b);
            e.dataNb[i*DW +: DW] = d; e.busyNb[i] = b;
        end
        expQ.push_back(e);
        #1;
        chk = expQ.pop_front();
        total++; if (readData !== chk.data) begin bad++; $display("FAIL %s data got=%h want=%h", name, readData, chk.data); end
        total++; if (readBusy !== chk.busy) begin bad++; $display("FAIL %s busy got=%b want=%b", name, readBusy, chk.busy); end
        total++; if (readDataNb !== chk.dataNb) begin bad++; $display("FAIL %s nbData got=%h want=%h", name, readDataNb, chk.dataNb); end
        total++; if (readBusyNb !== chk.busyNb) begin bad++; $display("FAIL %s nbBusy got=%b want=%b", name, readBusyNb, chk.busyNb); end
        total++; if (busyCount !== chk.cnt || busyCountNb !== chk.cnt) begin
            bad++; $display("FAIL %s count got=%0d/%0d want=%0d", name, busyCount, busyCountNb, chk.cnt);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd3, 5'd3, 5'd0);
        tick();
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
        score("reset");
        total++; if (readDataNb[DW-1:0] !== 32'h0 || busyCount !== 6'd0) begin
            bad++; $display("FAIL reset got=%h/%0d want=0/0", readDataNb[DW-1:0], busyCount);
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 5'd1, 32'd68, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drive(1'b0, 1'b1, 5'd2, 32'd82, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        score("writeRead");
        total++; if (readData !== {32'd82, 32'd68} || readBusy !== 2'b00 || busyCount !== 6'd0) begin
            bad++; $display("FAIL writeRead got=%h/%b/%0d want=%h/00/0", readData, readBusy, busyCount, {32'd82, 32'd68});
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 1'b1, 5'd0, 32'd55, 1'b1, 5'd0, 5'd0, 5'd0);
        score("zeroSame");
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        score("zeroAfter");
        total++; if (readData !== 64'h0 || readBusy !== 2'b00 || busyCount !== 6'd0) begin
            bad++; $display("FAIL zeroReg got=%h/%b/%0d want=0/00/0", readData, readBusy, busyCount);
        end
    endtask

    task automatic test_bypass();
        drive(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd3, 5'd1);
        score("bypassSame");
        total++; if (readData[DW-1:0] !== 32'hDEAD_BEEF || readDataNb[DW-1:0] !== 32'h0) begin
            bad++; $display("FAIL bypassSame got=%h/%h want=deadbeef/0", readData[DW-1:0], readDataNb[DW-1:0]);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
        score("bypassAfter");
        total++; if (readDataNb[DW-1:0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL bypassAfter got=%h want=deadbeef", readDataNb[DW-1:0]);
        end
    endtask

    task automatic test_busy();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd6);
        score("rsv5Same");
        total++; if (readBusy !== 2'b00) begin bad++; $display("FAIL rsvNoBypass got=%b want=00", readBusy); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
        score("rsv6Same");
        total++; if (busyCount !== 6'd1) begin bad++; $display("FAIL count1 got=%0d want=1", busyCount); end
        tick();
        drive(1'b0, 1'b1, 5'd5, 32'd7, 1'b0, 5'd0, 5'd5, 5'd6);
        score("wr5Same");
        total++; if (busyCount !== 6'd2 || readBusy !== 2'b10 || readBusyNb !== 2'b11) begin
            bad++; $display("FAIL count2 got=%0d/%b/%b want=2/10/11", busyCount, readBusy, readBusyNb);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
        score("rsv6Again");
        total++; if (busyCount !== 6'd1 || readBusy !== 2'b10 || readData[DW-1:0] !== 32'd7) begin
            bad++; $display("FAIL clear5 got=%0d/%b/%h want=1/10/7", busyCount, readBusy, readData[DW-1:0]);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        score("rsvBusy");
        total++; if (busyCount !== 6'd1) begin bad++; $display("FAIL rsvBusy got=%0d want=1", busyCount); end
    endtask

    task automatic test_same_cycle();
        drive(1'b0, 1'b1, 5'd9, 32'd12, 1'b1, 5'd9, 5'd9, 5'd6);
        score("sameCycle");
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd6);
        score("sameAfter");
        total++; if (readData[DW-1:0] !== 32'd12 || readBusy[0] !== 1'b1 || busyCount !== 6'd2) begin
            bad++; $display("FAIL sameCycle got=%h/%b/%0d want=c/1/2", readData[DW-1:0], readBusy[0], busyCount);
        end
    endtask

    task automatic test_reset_busy();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd7);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd4, 5'd7);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd4, 5'd8);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd8);
        score("rsvThree");
        total++; if (busyCount !== 6'd5) begin bad++; $display("FAIL rsvThree got=%0d want=5", busyCount); end
        drive(1'b1, 1'b1, 5'd4, 32'd99, 1'b0, 5'd0, 5'd4, 5'd8);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
        score("rstBusy");
        total++; if (readData !== 64'h0 || readBusy !== 2'b00 || busyCount !== 6'd0) begin
            bad++; $display("FAIL rstBusy got=%h/%b/%0d want=0/00/0", readData, readBusy, busyCount);
        end
    endtask

    task automatic test_fill();
        for (int r = 0; r < DEPTH; r++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, AW'(r), AW'(r), 5'd31);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd0, 5'd31);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd31);
        score("fill");
        total++; if (busyCount !== 6'd31) begin bad++; $display("FAIL fill got=%0d want=31", busyCount); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                  AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            score("random");
            tick();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int r = 0; r < DEPTH; r++) begin
            mMem[r] = 'x; mBusy[r] = 1'bx;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_busy();
        test_same_cycle();
        test_reset_busy();
        test_fill();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
